// File: rtl/rs_issue_queue_if.sv
// rs_issue_queue_if: bundle of every non-clock/reset signal of rs_issue_queue.
//   Dispatch : in_valid/in_ready handshake plus the renamed op payload (in_*).
//   Wakeup   : wk_valid, packed wk_tag / wk_val; bus i sits at [i*W +: W].
//   Issue    : fu_ready per FU in; iss_valid and packed iss_* payload out.
//   Control  : flush in; count (occupied entries) out.
// The master modport is the surrounding pipeline; the slave modport is the queue.
interface rs_issue_queue_if #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_FU     = 3,
  parameter int unsigned NUM_WAKEUP = 4,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned ROB_W      = 6,
  parameter int unsigned DATA_W     = 32
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [TAG_W-1:0]             in_rd;
  logic [TAG_W-1:0]             in_rs1;
  logic [TAG_W-1:0]             in_rs2;
  logic                         in_rs1_rdy;
  logic                         in_rs2_rdy;
  logic [DATA_W-1:0]            in_rs1_val;
  logic [DATA_W-1:0]            in_rs2_val;
  logic [DATA_W-1:0]            in_imm;
  logic [3:0]                   in_alu_ctrl;
  logic                         in_alusrc;
  logic                         in_is_ls;
  logic [ROB_W-1:0]             in_rob;

  logic [NUM_WAKEUP-1:0]        wk_valid;
  logic [NUM_WAKEUP*TAG_W-1:0]  wk_tag;
  logic [NUM_WAKEUP*DATA_W-1:0] wk_val;

  logic [NUM_FU-1:0]            fu_ready;
  logic                         flush;

  logic [NUM_FU-1:0]            iss_valid;
  logic [NUM_FU*TAG_W-1:0]      iss_rd;
  logic [NUM_FU*ROB_W-1:0]      iss_rob;
  logic [NUM_FU*DATA_W-1:0]     iss_rs1_val;
  logic [NUM_FU*DATA_W-1:0]     iss_rs2_val;
  logic [NUM_FU*DATA_W-1:0]     iss_imm;
  logic [NUM_FU*4-1:0]          iss_alu_ctrl;
  logic [NUM_FU-1:0]            iss_alusrc;
  logic [NUM_FU-1:0]            iss_is_ls;
  logic [CNT_W-1:0]             count;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_rs1_rdy, in_rs2_rdy,
           in_rs1_val, in_rs2_val, in_imm, in_alu_ctrl, in_alusrc, in_is_ls,
           in_rob, wk_valid, wk_tag, wk_val, fu_ready, flush,
    input  in_ready, iss_valid, iss_rd, iss_rob, iss_rs1_val, iss_rs2_val,
           iss_imm, iss_alu_ctrl, iss_alusrc, iss_is_ls, count
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_rs1_rdy, in_rs2_rdy,
           in_rs1_val, in_rs2_val, in_imm, in_alu_ctrl, in_alusrc, in_is_ls,
           in_rob, wk_valid, wk_tag, wk_val, fu_ready, flush,
    output in_ready, iss_valid, iss_rd, iss_rob, iss_rs1_val, iss_rs2_val,
           iss_imm, iss_alu_ctrl, iss_alusrc, iss_is_ls, count
  );
endinterface

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: multi-issue reservation station between dispatch and the FUs.
//   clk   : rising-edge clock.
//   reset : synchronous, active-low.
//   rsq   : rs_issue_queue_if slave port (dispatch, wakeup, issue, flush, count).
// Holds up to DEPTH renamed ops, captures operands from NUM_WAKEUP broadcast
// buses (including same-cycle bypass on allocation) and issues up to NUM_FU
// ready ops per cycle, strictly oldest-first, onto the ready FUs in ascending
// index order. Issue outputs are registered.
module rs_issue_queue #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_FU     = 3,
  parameter int unsigned NUM_WAKEUP = 4,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned ROB_W      = 6,
  parameter int unsigned DATA_W     = 32
) (
  input  logic            clk,
  input  logic            reset,
  rs_issue_queue_if.slave rsq
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  rs1;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1_val;
    logic [TAG_W-1:0]  rs2;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_ctrl;
    logic              alusrc;
    logic              is_ls;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  rd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_ctrl;
    logic              alusrc;
    logic              is_ls;
  } iss_t;

  entry_t            ent_q     [DEPTH];
  entry_t            ent_d     [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  // older_q[i][j] set means entry i was allocated before entry j.
  logic [DEPTH-1:0]  older_q   [DEPTH];
  logic [DEPTH-1:0]  older_d   [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NUM_FU-1:0] iss_valid_q, iss_valid_d;
  iss_t              iss_q     [NUM_FU];
  iss_t              iss_d     [NUM_FU];

  logic [DEPTH-1:0]  elig;
  logic [CNT_W-1:0]  rank      [DEPTH];
  logic [NUM_FU-1:0] sel_vld;
  logic [IDX_W-1:0]  sel_idx   [NUM_FU];
  logic [DEPTH-1:0]  issue_mask;
  logic [CNT_W-1:0]  num_iss;
  logic [IDX_W-1:0]  free_idx;
  logic              alloc;
  entry_t            alloc_ent;

  // Returns {hit, value}; the lowest-index matching bus wins.
  function automatic logic [DATA_W:0] wk_match(
    input logic [NUM_WAKEUP-1:0]        v,
    input logic [NUM_WAKEUP*TAG_W-1:0]  tags,
    input logic [NUM_WAKEUP*DATA_W-1:0] vals,
    input logic [TAG_W-1:0]             tag
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int unsigned b = 0; b < NUM_WAKEUP; b++) begin
      if (!r[DATA_W] && v[b] && (tags[b*TAG_W +: TAG_W] == tag))
        r = {1'b1, vals[b*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  // Eligibility uses registered readiness only, so a wakeup or allocation at
  // edge E can be selected at edge E+1 at the earliest.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++)
      elig[i] = valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
  end

  // Rank = number of eligible entries older than this one; rank r goes to
  // the r-th ready FU.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (elig[j] && older_q[j][i])
          rank[i] = rank[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    logic [CNT_W-1:0] pos;
    pos        = '0;
    sel_vld    = '0;
    issue_mask = '0;
    num_iss    = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      sel_idx[f] = '0;
      if (rsq.fu_ready[f]) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (elig[i] && (rank[i] == pos)) begin
            sel_vld[f]    = 1'b1;
            sel_idx[f]    = IDX_W'(i);
            issue_mask[i] = 1'b1;
          end
        end
        pos = pos + CNT_W'(1);
      end
      if (sel_vld[f])
        num_iss = num_iss + CNT_W'(1);
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && !valid_q[i]) begin
        found    = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign rsq.in_ready = (count_q < CNT_W'(DEPTH));
  assign alloc = rsq.in_valid && rsq.in_ready && (rsq.in_alu_ctrl != 4'd0) && !rsq.flush;

  // Incoming op with allocation-time wakeup bypass on not-ready sources.
  always_comb begin
    logic [DATA_W:0] m1;
    logic [DATA_W:0] m2;
    m1 = wk_match(rsq.wk_valid, rsq.wk_tag, rsq.wk_val, rsq.in_rs1);
    m2 = wk_match(rsq.wk_valid, rsq.wk_tag, rsq.wk_val, rsq.in_rs2);
    alloc_ent.rd       = rsq.in_rd;
    alloc_ent.rs1      = rsq.in_rs1;
    alloc_ent.rs1_rdy  = rsq.in_rs1_rdy;
    alloc_ent.rs1_val  = rsq.in_rs1_val;
    alloc_ent.rs2      = rsq.in_rs2;
    alloc_ent.rs2_rdy  = rsq.in_rs2_rdy;
    alloc_ent.rs2_val  = rsq.in_rs2_val;
    alloc_ent.imm      = rsq.in_imm;
    alloc_ent.alu_ctrl = rsq.in_alu_ctrl;
    alloc_ent.alusrc   = rsq.in_alusrc;
    alloc_ent.is_ls    = rsq.in_is_ls;
    alloc_ent.rob      = rsq.in_rob;
    if (!rsq.in_rs1_rdy && m1[DATA_W]) begin
      alloc_ent.rs1_rdy = 1'b1;
      alloc_ent.rs1_val = m1[DATA_W-1:0];
    end
    if (!rsq.in_rs2_rdy && m2[DATA_W]) begin
      alloc_ent.rs2_rdy = 1'b1;
      alloc_ent.rs2_val = m2[DATA_W-1:0];
    end
  end

  always_comb begin
    logic [DATA_W:0] m;
    m       = '0;
    ent_d   = ent_q;
    older_d = older_q;
    valid_d = valid_q & ~issue_mask;
    count_d = count_q + CNT_W'(alloc) - num_iss;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !ent_q[i].rs1_rdy) begin
        m = wk_match(rsq.wk_valid, rsq.wk_tag, rsq.wk_val, ent_q[i].rs1);
        if (m[DATA_W]) begin
          ent_d[i].rs1_rdy = 1'b1;
          ent_d[i].rs1_val = m[DATA_W-1:0];
        end
      end
      if (valid_q[i] && !ent_q[i].rs2_rdy) begin
        m = wk_match(rsq.wk_valid, rsq.wk_tag, rsq.wk_val, ent_q[i].rs2);
        if (m[DATA_W]) begin
          ent_d[i].rs2_rdy = 1'b1;
          ent_d[i].rs2_val = m[DATA_W-1:0];
        end
      end
    end

    // New entry is younger than everything; stale bits of invalid entries
    // are harmless because only eligible entries are ever compared.
    if (alloc) begin
      ent_d[free_idx]   = alloc_ent;
      valid_d[free_idx] = 1'b1;
      older_d[free_idx] = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (IDX_W'(j) != free_idx)
          older_d[j][free_idx] = 1'b1;
      end
    end

    iss_valid_d = sel_vld;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      iss_d[f] = iss_q[f];
      if (sel_vld[f]) begin
        iss_d[f].rd       = ent_q[sel_idx[f]].rd;
        iss_d[f].rob      = ent_q[sel_idx[f]].rob;
        iss_d[f].rs1_val  = ent_q[sel_idx[f]].rs1_val;
        iss_d[f].rs2_val  = ent_q[sel_idx[f]].rs2_val;
        iss_d[f].imm      = ent_q[sel_idx[f]].imm;
        iss_d[f].alu_ctrl = ent_q[sel_idx[f]].alu_ctrl;
        iss_d[f].alusrc   = ent_q[sel_idx[f]].alusrc;
        iss_d[f].is_ls    = ent_q[sel_idx[f]].is_ls;
      end
    end

    if (rsq.flush) begin
      valid_d     = '0;
      count_d     = '0;
      iss_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= '0;
      count_q     <= '0;
      iss_valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
      for (int unsigned f = 0; f < NUM_FU; f++)
        iss_q[f] <= '0;
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      iss_valid_q <= iss_valid_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
      for (int unsigned f = 0; f < NUM_FU; f++)
        iss_q[f] <= iss_d[f];
    end
  end

  assign rsq.count     = count_q;
  assign rsq.iss_valid = iss_valid_q;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_iss
    assign rsq.iss_rd[f*TAG_W +: TAG_W]        = iss_q[f].rd;
    assign rsq.iss_rob[f*ROB_W +: ROB_W]       = iss_q[f].rob;
    assign rsq.iss_rs1_val[f*DATA_W +: DATA_W] = iss_q[f].rs1_val;
    assign rsq.iss_rs2_val[f*DATA_W +: DATA_W] = iss_q[f].rs2_val;
    assign rsq.iss_imm[f*DATA_W +: DATA_W]     = iss_q[f].imm;
    assign rsq.iss_alu_ctrl[f*4 +: 4]          = iss_q[f].alu_ctrl;
    assign rsq.iss_alusrc[f]                   = iss_q[f].alusrc;
    assign rsq.iss_is_ls[f]                    = iss_q[f].is_ls;
  end
endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed self-checking bench for rs_issue_queue with
// default parameters (DEPTH=16, NUM_FU=3, NUM_WAKEUP=4, TAG_W=6, ROB_W=6, DATA_W=32).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_rs_issue_queue;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  rs_issue_queue_if #(
    .DEPTH(16), .NUM_FU(3), .NUM_WAKEUP(4), .TAG_W(6), .ROB_W(6), .DATA_W(32)
  ) bus ();

  rs_issue_queue #(
    .DEPTH(16), .NUM_FU(3), .NUM_WAKEUP(4), .TAG_W(6), .ROB_W(6), .DATA_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rsq   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_alu_ctrl = 4'd0;
    bus.wk_valid    = '0;
    bus.wk_tag      = '0;
    bus.wk_val      = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_op(input logic [5:0] rd, input logic [5:0] rs1, input logic r1,
                        input logic [31:0] v1, input logic [5:0] rs2, input logic r2,
                        input logic [31:0] v2, input logic [5:0] rob, input logic [3:0] alu);
    bus.in_valid    = 1'b1;
    bus.in_rd       = rd;
    bus.in_rs1      = rs1;
    bus.in_rs1_rdy  = r1;
    bus.in_rs1_val  = v1;
    bus.in_rs2      = rs2;
    bus.in_rs2_rdy  = r2;
    bus.in_rs2_val  = v2;
    bus.in_rob      = rob;
    bus.in_imm      = 32'h7;
    bus.in_alu_ctrl = alu;
    bus.in_alusrc   = 1'b1;
    bus.in_is_ls    = 1'b0;
  endtask

  task automatic set_wk(input int unsigned b, input logic [5:0] tag, input logic [31:0] val);
    bus.wk_valid[b]           = 1'b1;
    bus.wk_tag[b*6 +: 6]      = tag;
    bus.wk_val[b*32 +: 32]    = val;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bus.fu_ready = '0;
    set_op(6'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 4'd0);
    idle();

    // Reset held low for two edges
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("rst_iss_rd", 64'(bus.iss_rd), 64'd0);
    reset = 1'b1;
    bus.fu_ready = 3'b111;

    // nop (alu_ctrl 0) is dropped
    set_op(6'd1, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd1, 4'd0);
    step();
    check("nop_count", 64'(bus.count), 64'd0);
    idle();
    step();
    check("nop_no_issue", 64'(bus.iss_valid), 64'd0);

    // Single ready op
    set_op(6'd5, 6'd1, 1'b1, 32'h10, 6'd2, 1'b1, 32'h20, 6'd3, 4'h3);
    step();
    check("single_count_alloc", 64'(bus.count), 64'd1);
    check("single_no_early_issue", 64'(bus.iss_valid), 64'd0);
    idle();
    step();
    check("single_iss_valid", 64'(bus.iss_valid), 64'b001);
    check("single_iss_rd", 64'(bus.iss_rd[5:0]), 64'd5);
    check("single_iss_rob", 64'(bus.iss_rob[5:0]), 64'd3);
    check("single_rs1_val", 64'(bus.iss_rs1_val[31:0]), 64'h10);
    check("single_rs2_val", 64'(bus.iss_rs2_val[31:0]), 64'h20);
    check("single_alu", 64'(bus.iss_alu_ctrl[3:0]), 64'h3);
    check("single_imm", 64'(bus.iss_imm[31:0]), 64'h7);
    check("single_count_after", 64'(bus.count), 64'd0);
    step();
    check("single_one_cycle", 64'(bus.iss_valid), 64'd0);

    // A waits on tag 9, younger B is ready and issues first
    set_op(6'd6, 6'd9, 1'b0, 32'h0, 6'd3, 1'b1, 32'h2, 6'd4, 4'h1);
    step();
    set_op(6'd7, 6'd4, 1'b1, 32'h3, 6'd5, 1'b1, 32'h4, 6'd5, 4'h1);
    step();
    check("ab_count", 64'(bus.count), 64'd2);
    idle();
    step();
    check("ab_b_valid", 64'(bus.iss_valid), 64'b001);
    check("ab_b_rd", 64'(bus.iss_rd[5:0]), 64'd7);
    set_wk(2, 6'd9, 32'hDEAD);
    step();
    check("ab_wake_edge_no_issue", 64'(bus.iss_valid), 64'd0);
    check("ab_count_mid", 64'(bus.count), 64'd1);
    idle();
    step();
    check("ab_a_valid", 64'(bus.iss_valid), 64'b001);
    check("ab_a_rd", 64'(bus.iss_rd[5:0]), 64'd6);
    check("ab_a_rs1_val", 64'(bus.iss_rs1_val[31:0]), 64'hDEAD);
    check("ab_a_rs2_val", 64'(bus.iss_rs2_val[31:0]), 64'h2);
    check("ab_count_end", 64'(bus.count), 64'd0);

    // Allocation bypass; buses 0 and 3 both match tag 12, bus 0 wins;
    // rs1 carries tag 12 but is already ready and must keep its value
    set_op(6'd8, 6'd12, 1'b1, 32'h1, 6'd12, 1'b0, 32'h0, 6'd6, 4'h2);
    set_wk(0, 6'd12, 32'h55);
    set_wk(3, 6'd12, 32'h99);
    step();
    idle();
    step();
    check("byp_valid", 64'(bus.iss_valid), 64'b001);
    check("byp_rd", 64'(bus.iss_rd[5:0]), 64'd8);
    check("byp_rs2_val", 64'(bus.iss_rs2_val[31:0]), 64'h55);
    check("byp_rs1_kept", 64'(bus.iss_rs1_val[31:0]), 64'h1);

    // Age vs slot: fillers occupy 0..2, P lands in slot 3, then Q,R,S reuse 0,2,1
    set_op(6'd1, 6'd40, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd10, 4'h1); step();
    set_op(6'd2, 6'd41, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd11, 4'h1); step();
    set_op(6'd3, 6'd42, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd12, 4'h1); step();
    set_op(6'd10, 6'd30, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd20, 4'h1); step();
    idle();
    set_wk(0, 6'd40, 32'hA0);
    set_wk(1, 6'd42, 32'hA2);
    step();
    idle();
    step();
    check("age_fill_valid", 64'(bus.iss_valid), 64'b011);
    check("age_fill_rd0", 64'(bus.iss_rd[5:0]), 64'd1);
    check("age_fill_rd1", 64'(bus.iss_rd[11:6]), 64'd3);
    set_op(6'd11, 6'd30, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd21, 4'h1); step();
    set_op(6'd12, 6'd30, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd22, 4'h1);
    set_wk(0, 6'd41, 32'hA1);
    step();
    idle();
    step();
    check("age_f1_valid", 64'(bus.iss_valid), 64'b001);
    check("age_f1_rd", 64'(bus.iss_rd[5:0]), 64'd2);
    set_op(6'd13, 6'd30, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'd23, 4'h1); step();
    check("age_count4", 64'(bus.count), 64'd4);
    idle();
    set_wk(3, 6'd30, 32'h30);
    bus.fu_ready = 3'b101;
    step();
    check("age_wake_no_issue", 64'(bus.iss_valid), 64'd0);
    idle();
    step();
    check("age_e1_valid", 64'(bus.iss_valid), 64'b101);
    check("age_e1_fu0_rd", 64'(bus.iss_rd[5:0]), 64'd10);
    check("age_e1_fu2_rd", 64'(bus.iss_rd[17:12]), 64'd11);
    check("age_e1_fu0_rob", 64'(bus.iss_rob[5:0]), 64'd20);
    check("age_e1_rs1_val", 64'(bus.iss_rs1_val[31:0]), 64'h30);
    step();
    check("age_e2_valid", 64'(bus.iss_valid), 64'b101);
    check("age_e2_fu0_rd", 64'(bus.iss_rd[5:0]), 64'd12);
    check("age_e2_fu2_rd", 64'(bus.iss_rd[17:12]), 64'd13);
    check("age_count0", 64'(bus.count), 64'd0);
    bus.fu_ready = 3'b111;

    // Fill all 16 entries, extra op dropped, then flush
    for (int i = 0; i < 16; i++) begin
      set_op(6'(i), 6'd50, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 6'(i), 4'h1);
      step();
    end
    check("full_count", 64'(bus.count), 64'd16);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    set_op(6'd60, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h1, 6'd60, 4'h1);
    step();
    check("full_drop_count", 64'(bus.count), 64'd16);
    bus.flush = 1'b1;
    set_wk(0, 6'd50, 32'h5);
    step();
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_iss_valid", 64'(bus.iss_valid), 64'd0);
    idle();
    step();
    check("post_flush_no_issue", 64'(bus.iss_valid), 64'd0);
    check("post_flush_count", 64'(bus.count), 64'd0);

    // Reset in the middle of operation
    bus.fu_ready = 3'b000;
    set_op(6'd33, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h1, 6'd33, 4'h1);
    step();
    check("mid_count_before", 64'(bus.count), 64'd1);
    idle();
    reset = 1'b0;
    step();
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b1;
    bus.fu_ready = 3'b111;
    step();
    check("mid_rst_no_issue", 64'(bus.iss_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Parametrised successor to the single-issue-per-FU reservation station, sitting between rename/dispatch and the functional units.
- Holds up to DEPTH renamed ops and captures operand values from NUM_WAKEUP broadcast buses.
- Each cycle, issues up to NUM_FU ready ops, strictly oldest-first, to any ready FU.
- Adds three things the previous station lacks: dispatch backpressure, same-cycle wakeup bypass on allocation, and full flush.

Parameters:
- DEPTH, 16, number of entries (power of 2, 4..64).
- NUM_FU, 3, number of issue channels / functional units (1..4).
- NUM_WAKEUP, 4, number of wakeup broadcast buses.
- TAG_W, 6, physical register tag width.
- ROB_W, 6, ROB index width.
- DATA_W, 32, operand/immediate width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  dispatch offers an op this cycle.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_rd, in_rs1, in_rs2  in  TAG_W each  physical destination/source tags.
- in_rs1_rdy, in_rs2_rdy  in  1 each  source value already valid.
- in_rs1_val, in_rs2_val  in  DATA_W each  source values.
- in_imm  in  DATA_W  immediate.
- in_alu_ctrl  in  4  ALU operation; 0 = nop, never allocated.
- in_alusrc, in_is_ls  in  1 each  ALU source select; load/store flag.
- in_rob  in  ROB_W  ROB index.
- wk_valid  in  NUM_WAKEUP  per-bus valid.
- wk_tag  in  NUM_WAKEUP*TAG_W  packed tags, bus i at [i*TAG_W +: TAG_W].
- wk_val  in  NUM_WAKEUP*DATA_W  packed values.
- fu_ready  in  NUM_FU  FU f can accept an op next cycle.
- flush  in  1  discard all entries.
- iss_valid  out  NUM_FU  per-channel issue strobe.
- iss_rd, iss_rob  out  NUM_FU*TAG_W, NUM_FU*ROB_W  packed.
- iss_rs1_val, iss_rs2_val, iss_imm  out  NUM_FU*DATA_W each  packed.
- iss_alu_ctrl  out  NUM_FU*4  packed.
- iss_alusrc, iss_is_ls  out  NUM_FU each.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (reset==0 at edge): all entries invalid, count=0, iss_valid=0, all iss_* payloads=0, age state cleared. in_ready=1 in the first cycle after reset.
- Allocate: at an edge where in_valid && in_ready && in_alu_ctrl!=0 && !flush, write the lowest-index free entry. in_valid with in_alu_ctrl==0 is silently dropped.
- Allocation bypass: if an incoming source is not ready and matches an active wakeup bus that cycle, store it ready with the wakeup value. If several buses match, the lowest-index bus wins.
- Wakeup: at each edge, every valid entry with a not-ready source whose tag equals wk_tag[i] with wk_valid[i] captures wk_val[i] and sets ready. Lowest bus index wins on a multi-match. Already-ready sources are never overwritten.
- Issue eligibility: entry valid and both sources ready using registered state only. A wakeup at edge E makes the entry issuable at edge E+1. An op allocated at edge E issues at E+1 at the earliest.
- Selection: at each edge, take the ready FUs in ascending index order. Assign the oldest eligible entry to the first ready FU, the next oldest to the second, and so on. At most NUM_FU issues per cycle; an entry issues at most once.
- Age: strict allocation order (age matrix or per-entry sequence), independent of slot index and ROB index.
- Issue outputs are registered. iss_valid[f] is high for exactly one cycle after the selecting edge, with payload on channel f. The issued entry is freed at that same edge. iss_valid[f] is never high when fu_ready[f] was low at the selecting edge.
- Count: count_next = count + alloc - number_issued. Simultaneous alloc and issue when full: in_ready was 0, so no alloc; the slot is freed for the next cycle.
- Flush: takes priority over alloc, wakeup and issue. At that edge, all entries are invalidated, count=0 and iss_valid=0. In-flight iss_valid from the previous edge is unaffected.
- Reset mid-operation behaves exactly like reset from idle.

Test Plan:
- Reset low 2 cycles, then high -> in_ready=1, count=0, iss_valid=0.
- Alloc op (rd=5, rs1/rs2 ready, vals 0x10/0x20, rob=3), all FUs ready -> next cycle iss_valid=3'b001, iss_rd[0]=5, iss_rob[0]=3, count back to 0.
- Alloc A (rs1=9, not ready), then B (ready) -> B issues first. wk_valid[2]=1, wk_tag=9, wk_val=0xDEAD -> A issues one cycle later with rs1_val=0xDEAD.
- Bypass: alloc with rs2=12 not ready while wk_tag[0]=12, wk_val=0x55 -> issues next cycle with rs2_val=0x55.
- Four ready ops allocated oldest to youngest in slots 3,0,2,1; fu_ready=3'b101 -> one cycle later oldest on FU0, second on FU2, FU1 idle. Remaining two issue on the following edge.
- Fill DEPTH=16 non-ready ops -> in_ready=0, extra in_valid dropped. Assert flush -> count=0, in_ready=1, no issue on the following cycle.
